// File: rtl/word_pack_stream_pkg.sv
// Shared types and helpers for the word packer.
package word_pack_stream_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

  // Number of bytes needed to hold a given number of bits.
  function automatic int unsigned ceil_bytes(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/word_pack_oreg.sv
// Output word register with valid/ready handshake. Holds its contents
// stable while the consumer stalls; the packer loads it only when free.
module word_pack_oreg #(
  parameter int OUT_W = 64,
  parameter int BV_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic             load_last,
  input  logic [BV_W-1:0]  load_bv,
  output logic             free,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [BV_W-1:0]  out_bvalid,
  output logic [OUT_W-1:0] out_data
);

  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [BV_W-1:0]  bv_q, bv_d;
  logic [OUT_W-1:0] data_q, data_d;

  assign free       = !valid_q || out_ready;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign out_bvalid = bv_q;
  assign out_data   = data_q;

  // Load a new word, or drop valid once the current word is taken.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    bv_d    = bv_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      last_d  = load_last;
      bv_d    = load_bv;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Register update; reset discards any stalled word.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      bv_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      bv_q    <= bv_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/word_pack_stream.sv
// Packs variable-width LSB-aligned fields into fixed OUT_W-bit words.
// A beat that completes a word loads the output register on the same edge
// it is accepted, so the word is visible the following cycle.
module word_pack_stream
  import word_pack_stream_pkg::*;
#(
  parameter int OUT_W = 64,
  parameter int IN_W  = 64,
  localparam int SIZE_W = $clog2(IN_W) + 1,
  localparam int BV_W   = $clog2(OUT_W / 8) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [SIZE_W-1:0] in_size,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [BV_W-1:0]   out_bvalid,
  output logic [OUT_W-1:0]  out_data
);

  localparam int ACC_W  = 2 * OUT_W;
  localparam int FILL_W = $clog2(ACC_W);
  localparam int SUM_W  = FILL_W + 1;
  localparam logic [SUM_W-1:0] OUT_W_S = SUM_W'(OUT_W);

  pack_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_app;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SUM_W-1:0]  fill_app;
  logic [SIZE_W-1:0] size_sat;
  logic [IN_W-1:0]   data_m;
  logic              in_fire, oreg_free, last_pending, flush_now;
  logic              load, load_last;
  logic [OUT_W-1:0]  load_data;
  logic [BV_W-1:0]   load_bv;

  assign in_ready = !reset && (state_q == RUN) && (fill_q < FILL_W'(OUT_W));
  assign in_fire  = in_valid && in_ready;

  // Saturate the size and clear any bits above it.
  always_comb begin
    size_sat = (in_size > SIZE_W'(IN_W)) ? SIZE_W'(IN_W) : in_size;
    data_m   = in_data & ~({IN_W{1'b1}} << size_sat);
  end

  // Append the beat, then decide whether a word leaves the accumulator.
  // The final word of a stream stays in FLUSH until it is taken, so new
  // input only resumes once the stream is fully delivered.
  always_comb begin
    acc_app  = acc_q;
    fill_app = {1'b0, fill_q};
    if (in_fire) begin
      acc_app  = acc_q | ({{(ACC_W-IN_W){1'b0}}, data_m} << fill_q);
      fill_app = {1'b0, fill_q} + SUM_W'(size_sat);
    end
    last_pending = (state_q == FLUSH) && out_valid && out_last;
    flush_now    = (state_q == FLUSH) || (in_fire && in_last);

    state_d   = state_q;
    acc_d     = acc_app;
    fill_d    = fill_app[FILL_W-1:0];
    load      = 1'b0;
    load_data = acc_app[OUT_W-1:0];
    load_last = 1'b0;
    load_bv   = BV_W'(OUT_W / 8);

    if (in_fire && in_last) state_d = FLUSH;

    if (last_pending) begin
      if (out_ready) begin
        state_d = RUN;
        acc_d   = '0;
        fill_d  = '0;
      end
    end else if (oreg_free) begin
      if (flush_now && (fill_app <= OUT_W_S)) begin
        load      = 1'b1;
        load_last = 1'b1;
        load_bv   = BV_W'(ceil_bytes(32'(fill_app)));
        acc_d     = '0;
        fill_d    = '0;
      end else if (fill_app >= OUT_W_S) begin
        load   = 1'b1;
        acc_d  = acc_app >> OUT_W;
        fill_d = FILL_W'(fill_app - OUT_W_S);
      end
    end
  end

  // State, accumulator and fill registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
    end
  end

  word_pack_oreg #(
    .OUT_W(OUT_W),
    .BV_W (BV_W)
  ) u_oreg (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .load_bv   (load_bv),
    .free      (oreg_free),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_bvalid(out_bvalid),
    .out_data  (out_data)
  );

endmodule
